// File: rtl/mem_dados_ctx.sv
// MEM-stage data memory with base/limit relocation for user processes,
// a registered read port, and an OS/USER FSM that keeps one saved PC per process.
module mem_dados_ctx #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int DEPTH    = 64,
    parameter int NUM_CTX  = 4,
    parameter int CTX_W    = 2,
    parameter int OS_LIMIT = 687
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_write,
    input  logic              mem_read,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] limit,
    input  logic [ADDR_W-1:0] pc_atual,
    input  logic [ADDR_W-1:0] end_atual,
    input  logic [CTX_W-1:0]  proc_id,
    input  logic              fim,
    input  logic [CTX_W-1:0]  ctx_sel,
    output logic [ADDR_W-1:0] saida_pc,
    output logic [NUM_CTX-1:0] done_mask,
    output logic              fault,
    output logic              switch_evt,
    output logic              mode_user
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] OS_LIM  = ADDR_W'(OS_LIMIT);

    typedef enum logic {S_OS, S_USER} state_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] ctx [NUM_CTX];
    logic [CTX_W-1:0]  cur_proc;
    state_t            state, state_d;

    logic              user_pc;
    logic [ADDR_W:0]   phys;
    logic [IDX_W-1:0]  idx;
    logic              viol;
    logic              access;

    assign user_pc = pc_atual > OS_LIM;
    // One extra bit so that a carry out of base+addr lands above DEPTH.
    assign phys    = user_pc ? ({1'b0, base} + {1'b0, addr}) : {1'b0, addr};
    assign idx     = phys[IDX_W-1:0];
    assign viol    = (phys >= DEPTH_X) || (user_pc && (addr >= limit));
    assign access  = mem_read || mem_write;

    // Array left uninitialised on reset; only the read pipeline is cleared.
    always_ff @(posedge clk) begin
        if (mem_write && !viol)
            mem[idx] <= wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata  <= '0;
            rvalid <= 1'b0;
            fault  <= 1'b0;
        end else begin
            rvalid <= mem_read;
            fault  <= access && viol;
            if (mem_read)
                rdata <= viol ? '0 : mem[idx];
        end
    end

    logic save_pc, finish, leave_user, enter_user;

    always_comb begin
        state_d    = state;
        save_pc    = 1'b0;
        finish     = 1'b0;
        leave_user = 1'b0;
        enter_user = 1'b0;
        case (state)
            S_OS: begin
                if (user_pc) begin
                    state_d    = S_USER;
                    enter_user = 1'b1;
                end
            end
            S_USER: begin
                // A cycle already back in OS code is not a user PC worth saving.
                save_pc = user_pc;
                if (fim) begin
                    finish     = 1'b1;
                    leave_user = 1'b1;
                    state_d    = S_OS;
                end else if (!user_pc) begin
                    leave_user = 1'b1;
                    state_d    = S_OS;
                end
            end
            default: state_d = S_OS;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_OS;
            cur_proc   <= '0;
            done_mask  <= '0;
            switch_evt <= 1'b0;
            for (int i = 0; i < NUM_CTX; i++)
                ctx[i] <= '0;
        end else begin
            state      <= state_d;
            switch_evt <= leave_user;
            if (enter_user)
                cur_proc <= proc_id;
            if (save_pc)
                ctx[cur_proc] <= end_atual;
            if (finish)
                done_mask[cur_proc] <= 1'b1;
        end
    end

    assign saida_pc  = ctx[ctx_sel];
    assign mode_user = (state == S_USER);

endmodule

// File: tb/tb_mem_dados_ctx.sv
// Directed bench for mem_dados_ctx; read responses go through a scoreboard queue.
module tb_mem_dados_ctx;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_write, mem_read, fim;
    logic [31:0] addr, wdata, base, limit, pc_atual, end_atual;
    logic [1:0]  proc_id, ctx_sel;
    logic [31:0] rdata, saida_pc;
    logic [3:0]  done_mask;
    logic        rvalid, fault, switch_evt, mode_user;

    mem_dados_ctx dut (
        .clk(clk), .reset(reset), .mem_write(mem_write), .mem_read(mem_read),
        .addr(addr), .wdata(wdata), .rdata(rdata), .rvalid(rvalid),
        .base(base), .limit(limit), .pc_atual(pc_atual), .end_atual(end_atual),
        .proc_id(proc_id), .fim(fim), .ctx_sel(ctx_sel), .saida_pc(saida_pc),
        .done_mask(done_mask), .fault(fault), .switch_evt(switch_evt),
        .mode_user(mode_user)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct { logic [31:0] rd; logic f; int at; } exp_t;
    exp_t q[$];
    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every rvalid pops one expected read result.
    always @(negedge clk) begin
        if (!reset && rvalid) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_rvalid: got rdata %0h with no read pending", rdata);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rdata", 64'(rdata), 64'(e.rd));
                chk("read_fault", 64'(fault), 64'(e.f));
                chk("read_latency_cycle", 64'(cyc), 64'(e.at));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp_rd, input logic exp_f);
        mem_read = 1'b1; addr = a;
        q.push_back('{rd: exp_rd, f: exp_f, at: cyc + 1});
        step();
        mem_read = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic exp_f);
        mem_write = 1'b1; addr = a; wdata = d;
        step();
        mem_write = 1'b0;
        chk("write_fault", 64'(fault), 64'(exp_f));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; mem_write = 0; mem_read = 0; fim = 0;
        addr = 0; wdata = 0; base = 0; limit = 0; pc_atual = 0; end_atual = 0;
        proc_id = 0; ctx_sel = 0;
        step();
        chk("reset_rdata", 64'(rdata), 0);
        chk("reset_rvalid", 64'(rvalid), 0);
        chk("reset_fault", 64'(fault), 0);
        chk("reset_mode", 64'(mode_user), 0);
        chk("reset_done", 64'(done_mask), 0);
        chk("reset_slot0", 64'(saida_pc), 0);
        reset = 1'b0;
        step();

        // 1: OS mode direct access
        wr(5, 32'hDEADBEEF, 0);
        rd(5, 32'hDEADBEEF, 0);
        wr(48, 32'h4848, 0);
        wr(0, 32'h0A0A, 0);

        // 2: user relocation base=32 limit=16
        pc_atual = 700; end_atual = 700; base = 32; limit = 16; proc_id = 3;
        wr(3, 32'h1234, 0);
        rd(3, 32'h1234, 0);
        rd(16, 32'h0, 1);
        wr(16, 32'h5555, 1);
        step();
        chk("fault_one_cycle", 64'(fault), 0);

        // 3: out-of-range physical address and carry out
        base = 60;
        wr(4, 32'h7777, 1);
        wr(3, 32'h6363, 0);
        base = 32'hFFFF_FFFF;
        wr(1, 32'h9999, 1);

        // back to OS to inspect physical contents
        pc_atual = 0; end_atual = 0; base = 0; limit = 0;
        rd(35, 32'h1234, 0);
        rd(48, 32'h4848, 0);
        rd(0, 32'h0A0A, 0);
        rd(63, 32'h6363, 0);
        rd(64, 32'h0, 1);
        step();

        // 4: context save for process 2
        proc_id = 2;
        pc_atual = 690; end_atual = 690; step();
        chk("enter_user", 64'(mode_user), 1);
        pc_atual = 694; end_atual = 694; step();
        pc_atual = 698; end_atual = 698; step();
        pc_atual = 100; end_atual = 100; step();
        chk("switch_evt_pulse", 64'(switch_evt), 1);
        chk("back_to_os", 64'(mode_user), 0);
        ctx_sel = 2; #1;
        chk("slot2_pc", 64'(saida_pc), 698);
        chk("done_none", 64'(done_mask), 0);
        step();
        chk("switch_evt_clear", 64'(switch_evt), 0);

        // 5: termination of process 1
        proc_id = 1; pc_atual = 710; end_atual = 710; step();
        proc_id = 3;
        pc_atual = 720; end_atual = 720; fim = 1; step();
        fim = 0; pc_atual = 0; end_atual = 0;
        chk("done_p1", 64'(done_mask), 64'h2);
        chk("fim_to_os", 64'(mode_user), 0);
        chk("fim_switch_evt", 64'(switch_evt), 1);
        ctx_sel = 1; #1;
        chk("slot1_pc", 64'(saida_pc), 720);
        fim = 1; step(); step();
        fim = 0;
        chk("fim_in_os_ignored", 64'(done_mask), 64'h2);
        chk("fim_in_os_mode", 64'(mode_user), 0);

        // 6: read-first collision
        wr(7, 32'hA, 0);
        mem_write = 1; mem_read = 1; addr = 7; wdata = 32'hB;
        q.push_back('{rd: 32'hA, f: 1'b0, at: cyc + 1});
        step();
        mem_write = 0; mem_read = 0;
        rd(7, 32'hB, 0);
        step();

        // reset in USER with a read result on the bus
        proc_id = 0; pc_atual = 700; end_atual = 704; step(); step();
        chk("slot0_saved_pre_reset", 64'(dut.ctx[0]), 704);
        mem_read = 1; addr = 7;
        @(posedge clk); #2;
        mem_read = 0;
        reset = 1'b1; #1;
        chk("reset_kills_rvalid", 64'(rvalid), 0);
        chk("reset_mode_user", 64'(mode_user), 0);
        chk("reset_done_mask", 64'(done_mask), 0);
        for (int i = 0; i < 4; i++) begin
            ctx_sel = 2'(i); #1;
            chk("reset_slot", 64'(saida_pc), 0);
        end
        pc_atual = 0; end_atual = 0;
        step();
        reset = 1'b0;
        step(); step();
        chk("scoreboard_drained", 64'(q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
